intc_ctrl: RTL and testbench
============================

// Module: intc_ctrl
// PURPOSE
//  Interrupt controller directly downstream of the MCU timers and peripherals.
//  Latches source interrupt lines (timer intrup on src[0]) into a sticky pending register.
//  Applies a mask and a global enable, then selects the highest-priority request.
//  Presents one irq/vector request to the CPU, with an ack and end-of-interrupt (EOI) handshake.
//  Register access uses the same cs/wr/rd/datain/dataout bus style as the timer.
// PARAMETERS
//  NSRC   8    number of interrupt sources; 2..DW
//  DW     16   bus data width; matches timerwid
//  VECW   $clog2(NSRC)   vector width; derived, not overridable
// PORTS
//  clk      in   1     system clock; all logic on posedge
//  rst_n    in   1     synchronous reset, active-low
//  src      in   NSRC  interrupt source lines; src[0] = timer intrup
//  cs       in   1     register chip select
//  wr       in   1     write strobe; qualified by cs
//  rd       in   1     read strobe; qualified by cs
//  addr     in   2     register address
//  datain   in   DW    write data
//  dataout  out  DW    read data, registered
//  irq      out  1     interrupt request to CPU
//  irq_vec  out  VECW  index of the requesting source; valid while irq=1
//  irq_ack  in   1     CPU accepts the request; sampled only in REQ
// BEHAVIOUR
//  Reset (rst_n=0 at a posedge): pend, mask, gie, dataout, irq, irq_vec all 0; FSM=IDLE.
//  Registers (access only when cs=1):
//   0 PEND  read pend; write-1-to-clear
//   1 MASK  read/write; bit=1 enables the source
//   2 CTRL  bit0 = gie; other bits read 0
//   3 STAT  read {in_service, irq_vec}, zero-extended; any write = EOI
//  Read: cs&rd at cycle N -> dataout valid at N+1; dataout holds otherwise.
//  Write: takes effect at the end of the cycle in which it is issued.
//  Capture: a source event at cycle N sets pend[i] at N+1.
//   Set beats a same-cycle W1C or ack clear of that bit.
//  Priority: lowest index wins; req = pend & mask, considered only when gie=1.
//  FSM:
//   IDLE -> REQ when gie & |req; irq=1 and irq_vec latched one cycle after pend is seen.
//    Event at N -> irq at N+2.
//   REQ: irq_vec is frozen (no preemption by a higher-priority source).
//    irq_ack -> clear pend[irq_vec], go to SERVICE, irq=0 next cycle.
//    Latched bit W1C-cleared, masked, or gie=0 with no ack -> IDLE, irq=0 next cycle.
//    Ack takes precedence over a same-cycle withdrawal.
//   SERVICE: irq=0; in_service=1; new events still pend; EOI write -> IDLE.
//    EOI outside SERVICE is ignored.
//   irq_ack outside REQ is ignored.
//  rst_n low mid-operation: immediate return to reset state at that edge; pending events are lost.
//  Masked sources still set pend; unmasking later raises irq.
// CONFIGURATION
//  INTC_EDGE_DETECT_EN defined:
//   Event = rising edge of src[i] (src registered once internally).
//   A level held high sets pend once only.
//  INTC_EDGE_DETECT_EN undefined:
//   Event = src[i] high in any cycle (level).
//   pend re-sets each cycle while src is high, so W1C and ack are ineffective until src falls.
// STRUCTURE
//  intc_pkg: NSRC/DW defaults; address constants
//   (INTC_A_PEND=0, INTC_A_MASK=1, INTC_A_CTRL=2, INTC_A_STAT=3);
//   state enum {INTC_IDLE, INTC_REQ, INTC_SERVICE}.
//  Sub-module intc_prio_enc:
//   combinational NSRC -> {any, VECW index}; lowest index wins.
//  Register file, capture logic and FSM stay in intc_ctrl.
// TESTING
//  1. Reset, MASK=0x01, CTRL=1, pulse src[0] at N -> irq=1, vec=0 at N+2;
//     ack -> irq=0, STAT reads 0x8000 (in_service=1, DW=16); EOI -> STAT=0.
//  2. src[3] and src[1] in the same cycle, MASK=0xFF -> vec=1 first; after ack+EOI -> vec=3.
//  3. In REQ vec=5, src[2] fires -> vec stays 5 until ack; after EOI -> vec=2.
//  4. In REQ vec=4, write PEND=0x10 (W1C) -> irq=0 next cycle, FSM IDLE, no ack needed.
//  5. src[6] held high 10 cycles, ack + W1C: EDGE_EN -> single request;
//     level build -> pend[6] re-sets while high.
//  6. rst_n=0 while in SERVICE with pend=0x0A -> next cycle irq=0, pend=0, mask=0, dataout=0.

Source files
------------

// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared defaults, register map and FSM state type for the interrupt controller
// Purpose: default source count / bus width, register address constants and the
//          controller state enum used by intc_ctrl.
// Ports:   none (package).
package intc_pkg;

  localparam int INTC_NSRC = 8;
  localparam int INTC_DW   = 16;

  localparam logic [1:0] INTC_A_PEND = 2'd0;
  localparam logic [1:0] INTC_A_MASK = 2'd1;
  localparam logic [1:0] INTC_A_CTRL = 2'd2;
  localparam logic [1:0] INTC_A_STAT = 2'd3;

  typedef enum logic [1:0] {
    INTC_IDLE,
    INTC_REQ,
    INTC_SERVICE
  } intc_state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// rtl/intc_prio_enc.sv - combinational fixed-priority encoder, lowest index wins
// Purpose: reduce a request vector to {any, index of lowest set bit}.
// Ports:   req  in  NSRC  request bits
//          any  out 1     at least one request bit set
//          idx  out VECW  index of the lowest set bit (0 when none)
module intc_prio_enc #(
  parameter  int NSRC = 8,
  localparam int VECW = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req,
  output logic            any,
  output logic [VECW-1:0] idx
);

  // Scan from the top down so the last assignment is the lowest set index.
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = VECW'(i);
    end
  end

endmodule

// File: rtl/intc_ctrl.sv
// rtl/intc_ctrl.sv - interrupt controller: sticky pending, mask, global enable, irq/ack/EOI handshake
// Purpose: latches source events into pend, selects the lowest-index enabled request and
//          presents it to the CPU as irq/irq_vec; ack moves to service, a write to STAT is EOI.
// Config:  INTC_EDGE_DETECT_EN defined   -> events are rising edges of src
//          INTC_EDGE_DETECT_EN undefined -> events are src levels (pend re-sets while high)
// Ports:   clk, rst_n (sync, active-low)
//          src[NSRC]            interrupt source lines, src[0] = timer
//          cs, wr, rd, addr[2]  register bus strobes and address
//          datain[DW]           write data
//          dataout[DW]          registered read data, holds between reads
//          irq, irq_vec[VECW]   request to CPU and requesting source index
//          irq_ack              CPU accepts the request (only honoured while requesting)
module intc_ctrl
  import intc_pkg::*;
#(
  parameter  int NSRC = INTC_NSRC,
  parameter  int DW   = INTC_DW,
  localparam int VECW = $clog2(NSRC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] src,
  input  logic            cs,
  input  logic            wr,
  input  logic            rd,
  input  logic [1:0]      addr,
  input  logic [DW-1:0]   datain,
  output logic [DW-1:0]   dataout,
  output logic            irq,
  output logic [VECW-1:0] irq_vec,
  input  logic            irq_ack
);

  intc_state_e     state;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic            gie;

  logic [NSRC-1:0] evt;

`ifdef INTC_EDGE_DETECT_EN
  logic [NSRC-1:0] src_q;

  always_ff @(posedge clk) begin
    if (!rst_n) src_q <= '0;
    else        src_q <= src;
  end

  assign evt = src & ~src_q;
`else
  assign evt = src;
`endif

  logic wr_pend, wr_mask, wr_ctrl, wr_eoi, rd_en;

  assign wr_pend = cs & wr & (addr == INTC_A_PEND);
  assign wr_mask = cs & wr & (addr == INTC_A_MASK);
  assign wr_ctrl = cs & wr & (addr == INTC_A_CTRL);
  assign wr_eoi  = cs & wr & (addr == INTC_A_STAT);
  assign rd_en   = cs & rd;

  // Upper datain bits are unused when NSRC < DW.
  logic unused_datain;
  assign unused_datain = &{1'b0, datain};

  logic            ack_take;
  logic [NSRC-1:0] vec_bit;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] pend_nxt;
  logic [NSRC-1:0] mask_nxt;
  logic            gie_nxt;
  logic            keep;

  assign ack_take = (state == INTC_REQ) & irq_ack;
  assign vec_bit  = NSRC'(1) << irq_vec;
  assign clr      = (wr_pend ? datain[NSRC-1:0] : '0) | (ack_take ? vec_bit : '0);
  // OR-ing the event in last lets a new event win over a same-cycle clear.
  assign pend_nxt = (pend & ~clr) | evt;
  assign mask_nxt = wr_mask ? datain[NSRC-1:0] : mask;
  assign gie_nxt  = wr_ctrl ? datain[0] : gie;
  // The frozen request survives only if it is still pending, unmasked and enabled
  // after this cycle's register writes.
  assign keep     = gie_nxt & |(pend_nxt & mask_nxt & vec_bit);

  logic            req_any;
  logic [VECW-1:0] req_idx;

  intc_prio_enc #(.NSRC(NSRC)) u_prio (
    .req (pend & mask),
    .any (req_any),
    .idx (req_idx)
  );

  logic          in_service;
  logic [DW-1:0] rd_data;

  assign in_service = (state == INTC_SERVICE);

  always_comb begin
    rd_data = '0;
    case (addr)
      INTC_A_PEND: rd_data = DW'(pend);
      INTC_A_MASK: rd_data = DW'(mask);
      INTC_A_CTRL: rd_data[0] = gie;
      INTC_A_STAT: begin
        rd_data[VECW-1:0] = irq_vec;
        rd_data[DW-1]     = in_service;
      end
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= INTC_IDLE;
      pend    <= '0;
      mask    <= '0;
      gie     <= 1'b0;
      dataout <= '0;
      irq     <= 1'b0;
      irq_vec <= '0;
    end else begin
      pend <= pend_nxt;
      mask <= mask_nxt;
      gie  <= gie_nxt;
      if (rd_en) dataout <= rd_data;

      case (state)
        INTC_IDLE: begin
          if (gie && req_any) begin
            state   <= INTC_REQ;
            irq     <= 1'b1;
            irq_vec <= req_idx;
          end
        end
        INTC_REQ: begin
          if (irq_ack) begin
            state <= INTC_SERVICE;
            irq   <= 1'b0;
          end else if (!keep) begin
            state <= INTC_IDLE;
            irq   <= 1'b0;
          end
        end
        INTC_SERVICE: begin
          if (wr_eoi) state <= INTC_IDLE;
        end
        default: begin
          state <= INTC_IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intc_ctrl.sv
// tb/tb_intc_ctrl.sv - self-checking bench for intc_ctrl with a behavioural reference model
module tb_intc_ctrl;

  localparam int NSRC = 8;
  localparam int DW   = 16;
  localparam int VECW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NSRC-1:0] src = '0;
  logic            cs = 1'b0;
  logic            wr = 1'b0;
  logic            rd = 1'b0;
  logic [1:0]      addr = '0;
  logic [DW-1:0]   datain = '0;
  logic [DW-1:0]   dataout;
  logic            irq;
  logic [VECW-1:0] irq_vec;
  logic            irq_ack = 1'b0;

  intc_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .src     (src),
    .cs      (cs),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .datain  (datain),
    .dataout (dataout),
    .irq     (irq),
    .irq_vec (irq_vec),
    .irq_ack (irq_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = nothing presented, 1 = request presented awaiting ack, 2 = being serviced
  int       m_phase;
  bit [7:0] m_pend, m_mask, m_src_prev;
  bit       m_gie, m_irq, m_valid = 1'b0;
  int       m_vec;
  bit [15:0] m_dout;

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    bit [7:0] ev, clr, nmask, after;
    bit       ngie, w, r;
    if (!rst_n) begin
      m_phase = 0; m_pend = 0; m_mask = 0; m_gie = 0; m_irq = 0; m_vec = 0; m_dout = 0;
      m_src_prev = 0;
      m_valid = 1'b1;
    end else begin
`ifdef INTC_EDGE_DETECT_EN
      ev = src & ~m_src_prev;
`else
      ev = src;
`endif
      w = cs && wr;
      r = cs && rd;
      if (r) begin
        case (addr)
          2'd0: m_dout = {8'h00, m_pend};
          2'd1: m_dout = {8'h00, m_mask};
          2'd2: m_dout = {15'h0, m_gie};
          default: m_dout = (m_phase == 2 ? 16'h8000 : 16'h0000) + 16'(m_vec);
        endcase
      end
      clr   = (w && addr == 2'd0) ? datain[7:0] : 8'h00;
      nmask = (w && addr == 2'd1) ? datain[7:0] : m_mask;
      ngie  = (w && addr == 2'd2) ? datain[0]   : m_gie;
      if (m_phase == 0) begin
        if (m_gie && (m_pend & m_mask) != 0) begin
          m_phase = 1; m_irq = 1; m_vec = lowest(m_pend & m_mask);
        end
      end else if (m_phase == 1) begin
        if (irq_ack) begin
          clr[m_vec] = 1'b1;
          m_phase = 2; m_irq = 0;
        end else begin
          after = (m_pend & ~clr) | ev;
          if (!(after[m_vec] && nmask[m_vec] && ngie)) begin
            m_phase = 0; m_irq = 0;
          end
        end
      end else begin
        if (w && addr == 2'd3) m_phase = 0;
      end
      m_pend = (m_pend & ~clr) | ev;
      m_mask = nmask;
      m_gie  = ngie;
      m_src_prev = src;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("irq", irq, m_irq);
      if (m_irq) check("irq_vec", irq_vec, m_vec);
      check("dataout", dataout, m_dout);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    cs = 1; wr = 1; addr = a; datain = d;
    tick();
    cs = 0; wr = 0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    cs = 1; rd = 1; addr = a;
    tick();
    cs = 0; rd = 0;
  endtask

  task automatic ack_once();
    irq_ack = 1;
    tick();
    irq_ack = 0;
  endtask

  initial begin
    @(negedge clk);
    rst_n = 0;
    tick();
    check("reset_irq", irq, 0);
    check("reset_dataout", dataout, 0);
    rst_n = 1;

    // 1: timer source end to end
    bus_write(2'd1, 16'h0001);
    bus_write(2'd2, 16'h0001);
    src = 8'h01; tick(); src = 8'h00;
    check("t1_irq_at_n1", irq, 0);
    tick();
    check("t1_irq_at_n2", irq, 1);
    check("t1_vec", irq_vec, 0);
    ack_once();
    check("t1_irq_after_ack", irq, 0);
    bus_read(2'd3);
    check("t1_stat_service", dataout, 16'h8000);
    bus_write(2'd3, 16'h0000);
    bus_read(2'd3);
    check("t1_stat_after_eoi", dataout, 16'h0000);

    // 2: simultaneous sources, lowest index first
    bus_write(2'd1, 16'h00FF);
    src = 8'h0A; tick(); src = 8'h00; tick();
    check("t2_vec_first", irq_vec, 1);
    ack_once();
    bus_write(2'd3, 16'h0000);
    tick();
    check("t2_irq_second", irq, 1);
    check("t2_vec_second", irq_vec, 3);
    ack_once();
    bus_write(2'd3, 16'h0000);

    // 3: no preemption while requesting
    src = 8'h20; tick(); src = 8'h00; tick();
    check("t3_vec5", irq_vec, 5);
    src = 8'h04; tick(); src = 8'h00; tick();
    check("t3_vec_frozen", irq_vec, 5);
    ack_once();
    bus_write(2'd3, 16'h0000);
    tick();
    check("t3_vec2", irq_vec, 2);
    ack_once();
    bus_write(2'd3, 16'h0000);

    // 4: W1C withdraws the request
    src = 8'h10; tick(); src = 8'h00; tick();
    check("t4_vec4", irq_vec, 4);
    bus_write(2'd0, 16'h0010);
    check("t4_irq_withdrawn", irq, 0);
    tick();
    check("t4_irq_stays_low", irq, 0);
    bus_read(2'd0);
    check("t4_pend_clear", dataout, 0);

    // 5: held source
    bus_write(2'd1, 16'h0040);
    src = 8'h40; tick(); tick();
    check("t5_irq", irq, 1);
    ack_once();
    bus_write(2'd0, 16'h0040);
    repeat (4) tick();
    bus_read(2'd0);
`ifdef INTC_EDGE_DETECT_EN
    check("t5_pend_held_src", dataout, 16'h0000);
`else
    check("t5_pend_held_src", dataout, 16'h0040);
`endif
    src = 8'h00;
    bus_write(2'd3, 16'h0000);
    tick();
`ifdef INTC_EDGE_DETECT_EN
    check("t5_rerequest", irq, 0);
`else
    check("t5_rerequest", irq, 1);
`endif
    bus_write(2'd0, 16'h0040);
    tick();

    // 6: reset while servicing with pend=0x0A
    bus_write(2'd1, 16'h00FF);
    src = 8'h0A; tick(); src = 8'h00; tick();
    ack_once();
    src = 8'h02; tick(); src = 8'h00; tick();
    bus_read(2'd0);
    check("t6_pend_before_reset", dataout, 16'h000A);
    bus_read(2'd1);
    rst_n = 0;
    tick();
    rst_n = 1;
    check("t6_irq_reset", irq, 0);
    check("t6_dout_reset", dataout, 0);
    bus_read(2'd0);
    check("t6_pend_reset", dataout, 0);
    bus_read(2'd1);
    check("t6_mask_reset", dataout, 0);

    // randomized traffic against the model
    bus_write(2'd1, 16'h00FF);
    bus_write(2'd2, 16'h0001);
    for (int k = 0; k < 4000; k++) begin
      rst_n   = ($urandom_range(0, 299) != 0);
      src     = 8'($urandom & $urandom & $urandom);
      cs      = ($urandom_range(0, 2) == 0);
      wr      = 1'($urandom);
      rd      = 1'($urandom);
      addr    = 2'($urandom);
      datain  = 16'($urandom);
      if (addr == 2'd2) datain[0] = ($urandom_range(0, 3) != 0);
      if (addr == 2'd1) datain[7:0] = datain[7:0] | 8'($urandom);
      irq_ack = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst_n = 1; cs = 0; wr = 0; rd = 0; irq_ack = 0; src = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
